riscv_bp_gshare: RTL

Parametrised correlating branch predictor and successor to the fixed 2-bit concatenated-index predictor. Sits between the fetch/ID stages (read side) and the branch unit (write side) and supplies a per-parcel prediction one cycle after the fetch address is presented. Additions over the previous generation:
- internal global history register
- selectable index hashing (concatenate or XOR)
- N-bit saturating counters
- flop-based table with defined reset contents
- same-cycle write-to-read bypass

---
 rtl/riscv_bp_gshare_if.sv | 24 ++
 rtl/riscv_bp_gshare.sv | 67 ++++++
 2 files changed

// File: rtl/riscv_bp_gshare_if.sv
// riscv_bp_gshare_if: fetch-side read and branch-unit write bundle for the gshare predictor
interface riscv_bp_gshare_if #(
  parameter int XLEN           = 32,
  parameter int BP_GLOBAL_BITS = 4,
  parameter int BP_CNT_BITS    = 2
);
  logic                      id_stall;
  logic [XLEN-1:0]           if_parcel_pc;
  logic [BP_CNT_BITS-1:0]    bp_bp_predict;
  logic [BP_GLOBAL_BITS-1:0] bp_bp_history;
  logic [XLEN-1:0]           ex_pc;
  logic [BP_GLOBAL_BITS-1:0] bu_bp_history;
  logic [BP_CNT_BITS-1:0]    bu_bp_predict;
  logic                      bu_bp_btaken;
  logic                      bu_bp_update;
  modport master (
    output id_stall, if_parcel_pc, ex_pc, bu_bp_history, bu_bp_predict, bu_bp_btaken, bu_bp_update,
    input  bp_bp_predict, bp_bp_history
  );
  modport slave (
    input  id_stall, if_parcel_pc, ex_pc, bu_bp_history, bu_bp_predict, bu_bp_btaken, bu_bp_update,
    output bp_bp_predict, bp_bp_history
  );
endinterface

// File: rtl/riscv_bp_gshare.sv
// riscv_bp_gshare: gshare predictor with global history, 1-cycle registered read and write-to-read bypass
module riscv_bp_gshare #(
  parameter int              XLEN              = 32,
  parameter logic [XLEN-1:0] PC_INIT           = 'h200,
  parameter int              BP_GLOBAL_BITS    = 4,
  parameter int              BP_LOCAL_BITS     = 8,
  parameter int              BP_LOCAL_BITS_LSB = 2,
  parameter int              BP_CNT_BITS       = 2,
  parameter string           INDEX_MODE        = "CONCAT"
) (
  input logic             clk,
  input logic             rstn,
  riscv_bp_gshare_if.slave bp
);
  localparam int G = BP_GLOBAL_BITS;
  localparam int L = BP_LOCAL_BITS;
  localparam int C = BP_CNT_BITS;
  localparam int LSB = BP_LOCAL_BITS_LSB;
  localparam bit CAT = INDEX_MODE == "CONCAT";
  localparam int IDX = CAT ? G + L : L;
  localparam int N = 1 << IDX;
  localparam logic [C-1:0] WNT = {1'b0, {(C-1){1'b1}}};
  if (C < 2 || C > 4) begin : g_bad_cnt
    $error("riscv_bp_gshare: BP_CNT_BITS must be 2..4");
  end
  if (G < 1 || (!CAT && G > L)) begin : g_bad_hist
    $error("riscv_bp_gshare: BP_GLOBAL_BITS out of range for INDEX_MODE");
  end
  logic [C-1:0]    tbl_q [N];
  logic [XLEN-1:0] pc_dly_q;
  logic [G-1:0]    ghr_q, ghr_d, hist_q;
  logic [C-1:0]    pred_q, pred_d, upd;
  logic [L-1:0]    rpc_s;
  logic [IDX-1:0]  ridx, widx;
  logic            unused_pc;
  function automatic logic [IDX-1:0] hash(input logic [G-1:0] h, input logic [L-1:0] p);
    return CAT ? IDX'({h, p}) : IDX'(p ^ L'(h));
  endfunction
  always_comb begin
    rpc_s  = bp.id_stall ? pc_dly_q[LSB +: L] : bp.if_parcel_pc[LSB +: L];
    ridx   = hash(ghr_q, rpc_s);
    widx   = hash(bp.bu_bp_history, bp.ex_pc[LSB +: L]);
    upd    = bp.bu_bp_btaken ? (bp.bu_bp_predict == '1 ? bp.bu_bp_predict : bp.bu_bp_predict + 1'b1)
                             : (bp.bu_bp_predict == '0 ? bp.bu_bp_predict : bp.bu_bp_predict - 1'b1);
    pred_d = (bp.bu_bp_update && widx == ridx) ? upd : tbl_q[ridx];
    ghr_d  = bp.bu_bp_update ? G'({ghr_q, bp.bu_bp_btaken}) : ghr_q;
  end
  // history output is the pre-update ghr that formed this cycle's read index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= WNT;
      pc_dly_q <= PC_INIT;
      ghr_q    <= '0;
      hist_q   <= '0;
      pred_q   <= WNT;
    end else begin
      if (!bp.id_stall) pc_dly_q <= bp.if_parcel_pc;
      if (bp.bu_bp_update) tbl_q[widx] <= upd;
      ghr_q  <= ghr_d;
      hist_q <= ghr_q;
      pred_q <= pred_d;
    end
  end
  assign bp.bp_bp_predict = pred_q;
  assign bp.bp_bp_history = hist_q;
  assign unused_pc = ^{bp.if_parcel_pc, bp.ex_pc, pc_dly_q};
endmodule
